pc_gen_ras: RTL and testbench

Parametrised program-counter generator for the IFU, successor to the fixed 16-bit incrementer.
- Holds the fetch PC and presents it to fetch over a valid/ready handshake.
- Advances the PC by a configurable step, or redirects it on branch/jump, call or return.
- Contains a circular return-address stack (RAS) for call/return prediction.
- Sits between the execute-stage redirect path and the instruction-memory fetch port.

---
 rtl/ifu_pkg.sv | 15 +
 rtl/pc_gen_ras_if.sv | 25 ++
 rtl/ras_stack.sv | 53 +++++
 rtl/pc_gen_ras.sv | 120 ++++++++++++
 tb/tb_pc_gen_ras.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// Shared IFU types and defaults for the PC generator and its return-address stack.
package ifu_pkg;
    localparam int              DEF_WIDTH     = 16;
    localparam logic [15:0]     DEF_RESET_VEC = 16'hAA00;

    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} fsm_state_e;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_INC,
        SEL_REDIR,
        SEL_CALL,
        SEL_RET
    } sel_e;
endpackage

// File: rtl/pc_gen_ras_if.sv
// Fetch handshake, execute redirect and predecode call/return bundle around the PC generator.
interface pc_gen_ras_if #(parameter int WIDTH = 16);
    logic [WIDTH-1:0] pc_out;
    logic             pc_valid;
    logic             pc_ready;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_target;
    logic             call;
    logic [WIDTH-1:0] call_target;
    logic             ret;
    logic             ret_miss;
    logic             wrap;
    logic             ras_empty;
    logic             ras_full;

    modport master (
        output pc_out, pc_valid, ret_miss, wrap, ras_empty, ras_full,
        input  pc_ready, redirect_valid, redirect_target, call, call_target, ret
    );

    modport slave (
        input  pc_out, pc_valid, ret_miss, wrap, ras_empty, ras_full,
        output pc_ready, redirect_valid, redirect_target, call, call_target, ret
    );
endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full, pop on empty is ignored.
module ras_stack #(
    parameter int WIDTH     = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             replace,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);
    localparam int              PW      = $clog2(RAS_DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]    ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [PW-1:0]    top_idx;

    // ptr_reg is the next free slot; the top of stack sits just below it.
    assign top_idx = ptr_reg - PW'(1);
    assign top     = mem[top_idx];
    assign empty   = (count_reg == '0);
    assign full    = (count_reg == DEPTH_C);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr_reg] <= wdata;
        end else if (replace) begin
            mem[top_idx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg   <= '0;
            count_reg <= '0;
        end else if (push) begin
            ptr_reg <= ptr_reg + PW'(1);
            if (!full) begin
                count_reg <= count_reg + CW'(1);
            end
        end else if (pop && !empty) begin
            ptr_reg   <= top_idx;
            count_reg <= count_reg - CW'(1);
        end
    end
endmodule

// File: rtl/pc_gen_ras.sv
// Fetch PC generator: boot FSM, prioritised next-PC select, step incrementer and RAS prediction.
module pc_gen_ras
    import ifu_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               STEP      = 1,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
    parameter int               RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_gen_ras_if.master  bus
);
    localparam logic [0:0]     ST_BOOT  = 1'(BOOT);
    localparam logic [0:0]     ST_RUN   = 1'(RUN);
    localparam logic [WIDTH:0] STEP_EXT = (WIDTH + 1)'(STEP);

    logic [0:0]       state_reg, state_next;
    logic [WIDTH-1:0] pc_reg, pc_next;
    logic             pc_valid_reg;
    logic             ret_miss_reg, ret_miss_next;
    logic             wrap_reg, wrap_next;
    logic [WIDTH:0]   inc_ext;
    logic [WIDTH-1:0] pc_inc;
    logic             fire;
    sel_e             sel;
    logic             push, pop, replace;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty, ras_full;

    assign fire    = pc_valid_reg & bus.pc_ready;
    assign inc_ext = {1'b0, pc_reg} + STEP_EXT;
    assign pc_inc  = inc_ext[WIDTH-1:0];

    ras_stack #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .replace (replace),
        .wdata   (pc_inc),
        .top     (ras_top),
        .empty   (ras_empty),
        .full    (ras_full)
    );

    // A redirect wins over everything and suppresses any RAS update in the same cycle.
    always_comb begin
        sel           = SEL_HOLD;
        push          = 1'b0;
        pop           = 1'b0;
        replace       = 1'b0;
        ret_miss_next = 1'b0;
        if (bus.redirect_valid) begin
            sel = SEL_REDIR;
        end else if (fire && bus.call && bus.ret) begin
            if (!ras_empty) begin
                sel     = SEL_RET;
                replace = 1'b1;
            end else begin
                sel           = SEL_CALL;
                push          = 1'b1;
                ret_miss_next = 1'b1;
            end
        end else if (fire && bus.call) begin
            sel  = SEL_CALL;
            push = 1'b1;
        end else if (fire && bus.ret) begin
            if (!ras_empty) begin
                sel = SEL_RET;
                pop = 1'b1;
            end else begin
                sel           = SEL_INC;
                ret_miss_next = 1'b1;
            end
        end else if (fire) begin
            sel = SEL_INC;
        end
    end

    always_comb begin
        pc_next    = pc_reg;
        state_next = state_reg;
        wrap_next  = (sel == SEL_INC) && inc_ext[WIDTH];
        case (sel)
            SEL_INC:   pc_next = pc_inc;
            SEL_REDIR: pc_next = bus.redirect_target;
            SEL_CALL:  pc_next = bus.call_target;
            SEL_RET:   pc_next = ras_top;
            default:   pc_next = pc_reg;
        endcase
        case (state_reg)
            ST_BOOT: state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_BOOT;
            pc_reg       <= RESET_VEC;
            pc_valid_reg <= 1'b0;
            ret_miss_reg <= 1'b0;
            wrap_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            pc_valid_reg <= (state_next == ST_RUN);
            ret_miss_reg <= ret_miss_next;
            wrap_reg     <= wrap_next;
        end
    end

    assign bus.pc_out    = pc_reg;
    assign bus.pc_valid  = pc_valid_reg;
    assign bus.ret_miss  = ret_miss_reg;
    assign bus.wrap      = wrap_reg;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = ras_full;
endmodule

// File: tb/tb_pc_gen_ras.sv
// Scoreboard bench: two generator instances (STEP 1/depth 4, STEP 4/depth 2) against a list-based model.
module tb_pc_gen_ras;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_gen_ras_if #(.WIDTH(16)) bus0 ();
    pc_gen_ras_if #(.WIDTH(16)) bus1 ();

    pc_gen_ras #(.WIDTH(16), .STEP(1), .RESET_VEC(16'hAA00), .RAS_DEPTH(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    pc_gen_ras #(.WIDTH(16), .STEP(4), .RESET_VEC(16'hAA00), .RAS_DEPTH(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct packed {
        logic [15:0] pc;
        logic        valid;
        logic        miss;
        logic        wrap;
        logic        empty;
        logic        full;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          steps[2]  = '{1, 4};
    int          depths[2] = '{4, 2};
    logic [15:0] m_pc[2];
    logic        m_valid[2];
    logic [15:0] m_ras[2][4];
    int          m_n[2];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k]    = 16'hAA00;
            m_valid[k] = 1'b0;
            m_n[k]     = 0;
        end
    endtask

    // Return addresses kept as an ordered list, oldest at index 0.
    task automatic ras_push(input int k, input logic [15:0] v);
        if (m_n[k] == depths[k]) begin
            for (int i = 0; i < depths[k] - 1; i++) m_ras[k][i] = m_ras[k][i+1];
            m_ras[k][depths[k]-1] = v;
        end else begin
            m_ras[k][m_n[k]] = v;
            m_n[k]++;
        end
    endtask

    task automatic model_step(input int k, input logic rdy, input logic rv, input logic [15:0] rt,
                              input logic c, input logic [15:0] ct, input logic r);
        logic        fire;
        int          s;
        logic [15:0] t;
        exp_t        e;
        fire   = m_valid[k] & rdy;
        s      = int'(m_pc[k]) + steps[k];
        e.miss = 1'b0;
        e.wrap = 1'b0;
        if (rv) begin
            m_pc[k] = rt;
        end else if (fire && c && r) begin
            if (m_n[k] > 0) begin
                t = m_ras[k][m_n[k]-1];
                m_ras[k][m_n[k]-1] = 16'(s % 65536);
                m_pc[k] = t;
            end else begin
                ras_push(k, 16'(s % 65536));
                m_pc[k] = ct;
                e.miss  = 1'b1;
            end
        end else if (fire && c) begin
            ras_push(k, 16'(s % 65536));
            m_pc[k] = ct;
        end else if (fire && r && m_n[k] > 0) begin
            m_n[k]--;
            m_pc[k] = m_ras[k][m_n[k]];
        end else if (fire) begin
            e.miss  = r;
            e.wrap  = (s > 65535);
            m_pc[k] = 16'(s % 65536);
        end
        m_valid[k] = 1'b1;
        e.pc    = m_pc[k];
        e.valid = 1'b1;
        e.empty = (m_n[k] == 0);
        e.full  = (m_n[k] == depths[k]);
        exp_q.push_back(e);
    endtask

    // Drives one cycle of inputs, records the expected post-edge outputs, returns at edge+2.
    task automatic drive(input logic rdy, input logic rv, input logic [15:0] rt,
                         input logic c, input logic [15:0] ct, input logic r);
        bus0.pc_ready = rdy; bus0.redirect_valid = rv; bus0.redirect_target = rt;
        bus0.call = c; bus0.call_target = ct; bus0.ret = r;
        bus1.pc_ready = rdy; bus1.redirect_valid = rv; bus1.redirect_target = rt;
        bus1.call = c; bus1.call_target = ct; bus1.ret = r;
        for (int k = 0; k < 2; k++) model_step(k, rdy, rv, rt, c, ct, r);
        @(posedge clk);
        #2;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_pc0"}, bus0.pc_out, 16'hAA00);
        chk({tag, "_pc1"}, bus1.pc_out, 16'hAA00);
        chk({tag, "_valid0"}, 16'(bus0.pc_valid), 16'd0);
        chk({tag, "_valid1"}, 16'(bus1.pc_valid), 16'd0);
        chk({tag, "_empty0"}, 16'(bus0.ras_empty), 16'd1);
        chk({tag, "_full0"}, 16'(bus0.ras_full), 16'd0);
        chk({tag, "_miss0"}, 16'(bus0.ret_miss), 16'd0);
        chk({tag, "_wrap0"}, 16'(bus0.wrap), 16'd0);
    endtask

    // Monitor: compares the DUT outputs one step after each recorded transaction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() >= 2) begin
                for (int k = 0; k < 2; k++) begin
                    e = exp_q.pop_front();
                    if (k == 0) begin
                        chk("pc0", bus0.pc_out, e.pc);
                        chk("valid0", 16'(bus0.pc_valid), 16'(e.valid));
                        chk("ret_miss0", 16'(bus0.ret_miss), 16'(e.miss));
                        chk("wrap0", 16'(bus0.wrap), 16'(e.wrap));
                        chk("ras_empty0", 16'(bus0.ras_empty), 16'(e.empty));
                        chk("ras_full0", 16'(bus0.ras_full), 16'(e.full));
                    end else begin
                        chk("pc1", bus1.pc_out, e.pc);
                        chk("valid1", 16'(bus1.pc_valid), 16'(e.valid));
                        chk("ret_miss1", 16'(bus1.ret_miss), 16'(e.miss));
                        chk("wrap1", 16'(bus1.wrap), 16'(e.wrap));
                        chk("ras_empty1", 16'(bus1.ras_empty), 16'(e.empty));
                        chk("ras_full1", 16'(bus1.ras_full), 16'(e.full));
                    end
                end
                $display("t=%0t pc0=%h pc1=%h v=%b miss=%b%b wrap=%b%b empty=%b%b full=%b%b",
                         $time, bus0.pc_out, bus1.pc_out, bus0.pc_valid,
                         bus0.ret_miss, bus1.ret_miss, bus0.wrap, bus1.wrap,
                         bus0.ras_empty, bus1.ras_empty, bus0.ras_full, bus1.ras_full);
            end
        end
    end

    initial begin
        logic        rdy, rv, c, r;
        logic [15:0] rt, ct;
        drive_idle();
        model_reset();
        @(posedge clk);
        #2;
        reset_checks("reset");
        rst_n = 1'b1;

        // Boot then sequential fetch from the reset vector.
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        // Stall holds the PC, then resume.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        // Wrap past the top of the address space.
        drive(1'b1, 1'b1, 16'hFFFE, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        // Call at 0x0100 into 0x0200, run, then return.
        drive(1'b1, 1'b1, 16'h0100, 1'b0, 16'h0, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 1'b1, 16'h0200, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
        // Overflow the stack, drain it, then one return too many.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 16'h0, 1'b1, 16'(16'h3000 + i * 16'h0100), 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
        // Simultaneous call and return, on empty and on non-empty stack.
        drive(1'b1, 1'b0, 16'h0, 1'b1, 16'h5000, 1'b1);
        drive(1'b1, 1'b0, 16'h0, 1'b1, 16'h6000, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 1'b1, 16'h7000, 1'b1);
        // Redirect beats a call while stalled.
        drive(1'b0, 1'b1, 16'h1234, 1'b1, 16'h4444, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 9) == 0);
            c   = ($urandom_range(0, 5) == 0);
            r   = ($urandom_range(0, 5) == 0);
            rt  = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 2) == 0) rt = 16'hFFF0 | 16'($urandom_range(0, 15));
            ct  = 16'($urandom_range(0, 65535));
            drive(rdy, rv, rt, c, ct, r);
        end

        // Asynchronous reset mid-run, checked before any further clock edge.
        rst_n = 1'b0;
        #1;
        reset_checks("async_rst");
        @(posedge clk);
        #2;
        reset_checks("rst_hold");
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        chk("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic drive_idle();
        bus0.pc_ready = 1'b0; bus0.redirect_valid = 1'b0; bus0.redirect_target = '0;
        bus0.call = 1'b0; bus0.call_target = '0; bus0.ret = 1'b0;
        bus1.pc_ready = 1'b0; bus1.redirect_valid = 1'b0; bus1.redirect_target = '0;
        bus1.call = 1'b0; bus1.call_target = '0; bus1.ret = 1'b0;
    endtask
endmodule
